// File: rtl/bf_div_iter.sv
// Iterative bfloat16 divider: restoring significand division, one quotient bit
// per cycle, followed by a single normalise/round-to-nearest-even cycle.
module bf_div_iter #(
    parameter int NEXP = 8,
    parameter int NSIG = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NEXP+NSIG:0]     a,
    input  logic [NEXP+NSIG:0]     b,
    output logic                   busy,
    output logic                   done,
    output logic [NEXP+NSIG:0]     q,
    output logic [5:0]             bfFlags,
    output logic [4:0]             exception
);
    localparam int W  = NEXP + NSIG + 1;
    localparam int MW = NSIG + 1;          // significand incl. hidden bit
    localparam int RW = NSIG + 2;          // partial remainder
    localparam int QW = NSIG + 3;          // int + fraction + guard + round
    localparam int EW = NEXP + 3;          // signed working exponent
    localparam int CW = $clog2(QW);

    localparam logic [EW-1:0] E_ONE    = EW'(1);
    localparam logic [EW-1:0] E_BIAS   = EW'(2**(NEXP-1) - 1);
    localparam logic [EW-1:0] E_MAX    = EW'(2**NEXP - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);
    localparam logic [W-1:0]  QNAN_W   = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

    localparam logic [5:0] F_QNAN = 6'b010000;
    localparam logic [5:0] F_INF  = 6'b001000;
    localparam logic [5:0] F_ZERO = 6'b000100;
    localparam logic [5:0] F_SUB  = 6'b000010;
    localparam logic [5:0] F_NORM = 6'b000001;
    localparam logic [4:0] X_INV  = 5'b10000;
    localparam logic [4:0] X_DZ   = 5'b01000;
    localparam logic [4:0] X_OVF  = 5'b00100;

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_ROUND, S_DONE} state_t;
    state_t r_state, w_state_next;

    logic [W-1:0]  r_a, r_b, r_q;
    logic [5:0]    r_flags;
    logic [4:0]    r_exc;
    logic          r_sign;
    logic [EW-1:0] r_e;
    logic [MW-1:0] r_div;
    logic [RW-1:0] r_rem;
    logic [QW-1:0] r_quo;
    logic [CW-1:0] r_cnt;

    // ---------------- operand unpack ----------------
    logic [W-1:0]  w_op [2];
    logic [1:0]    w_sgn, w_zero, w_inf, w_nan, w_snan;
    logic [MW-1:0] w_man [2];
    logic [EW-1:0] w_exp [2];

    assign w_op[0] = r_a;
    assign w_op[1] = r_b;

    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
        logic [NEXP-1:0] w_ef;
        logic [NSIG-1:0] w_fr;
        logic [MW-1:0]   w_m;
        logic [EW-1:0]   w_sh;

        assign w_ef        = w_op[gi][W-2:NSIG];
        assign w_fr        = w_op[gi][NSIG-1:0];
        assign w_sgn[gi]   = w_op[gi][W-1];
        assign w_zero[gi]  = (w_ef == '0) && (w_fr == '0);
        assign w_inf[gi]   = (&w_ef) && (w_fr == '0);
        assign w_nan[gi]   = (&w_ef) && (w_fr != '0);
        assign w_snan[gi]  = w_nan[gi] && !w_fr[NSIG-1];

        // subnormals are left-justified so every finite operand looks like 1.xxx
        always_comb begin
            w_m  = {(w_ef != '0), w_fr};
            w_sh = '0;
            for (int k = 0; k < NSIG; k++) begin
                if (!w_m[NSIG]) begin
                    w_m  = w_m << 1;
                    w_sh = w_sh + E_ONE;
                end
            end
        end

        assign w_man[gi] = w_m;
        assign w_exp[gi] = ((w_ef == '0) ? E_ONE : {{(EW-NEXP){1'b0}}, w_ef}) - w_sh;
    end

    logic          w_sign, w_lt;
    logic [EW-1:0] w_e0, w_e_un;
    logic [W-1:0]  w_inf_q, w_zero_q;

    assign w_sign   = ^w_sgn;
    assign w_lt     = w_man[0] < w_man[1];
    assign w_e0     = w_exp[0] - w_exp[1] + E_BIAS;
    assign w_e_un   = w_lt ? (w_e0 - E_ONE) : w_e0;
    assign w_inf_q  = {w_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
    assign w_zero_q = {w_sign, {(W-1){1'b0}}};

    logic          w_spec;
    logic [W-1:0]  w_spec_q;
    logic [5:0]    w_spec_f;
    logic [4:0]    w_spec_x;

    always_comb begin
        w_spec   = 1'b1;
        w_spec_q = QNAN_W;
        w_spec_f = F_QNAN;
        w_spec_x = '0;
        if (|w_nan) begin
            w_spec_x = {|w_snan, 4'b0000};
        end else if ((&w_zero) || (&w_inf)) begin
            w_spec_x = X_INV;
        end else if (w_zero[1]) begin
            w_spec_q = w_inf_q;
            w_spec_f = F_INF;
            w_spec_x = X_DZ;
        end else if (w_inf[0]) begin
            w_spec_q = w_inf_q;
            w_spec_f = F_INF;
        end else if (w_inf[1] || w_zero[0]) begin
            w_spec_q = w_zero_q;
            w_spec_f = F_ZERO;
        end else begin
            w_spec   = 1'b0;
        end
    end

    // ---------------- restoring divide step ----------------
    logic [RW:0]   w_trial;
    logic          w_qbit;
    logic [RW-1:0] w_rem_keep, w_rem_next;

    assign w_trial    = {1'b0, r_rem} - {2'b00, r_div};
    assign w_qbit     = ~w_trial[RW];
    assign w_rem_keep = w_qbit ? w_trial[RW-1:0] : r_rem;
    assign w_rem_next = w_rem_keep << 1;

    // ---------------- normalise / round ----------------
    logic          w_tiny, w_lost, w_st, w_g, w_r, w_inc, w_inexact, w_ovf;
    logic [EW-1:0] w_shamt, w_e_rnd;
    logic [QW-1:0] w_al;
    logic [MW:0]   w_sum;

    assign w_tiny    = r_e[EW-1] || (r_e == '0);
    assign w_shamt   = w_tiny ? (E_ONE - r_e) : '0;
    assign w_lost    = |(r_quo & ~({QW{1'b1}} << w_shamt));
    assign w_al      = r_quo >> w_shamt;
    assign w_st      = (r_rem != '0) || w_lost;
    assign w_g       = w_al[1];
    assign w_r       = w_al[0];
    assign w_inc     = w_g && (w_r || w_st || w_al[2]);
    assign w_sum     = {1'b0, w_al[QW-1:2]} + {{MW{1'b0}}, w_inc};
    assign w_inexact = w_g || w_r || w_st;
    assign w_e_rnd   = w_sum[MW] ? (r_e + E_ONE) : r_e;
    assign w_ovf     = !w_tiny && (w_e_rnd >= E_MAX);

    logic [W-1:0]  w_rnd_q;
    logic [5:0]    w_rnd_f;
    logic [4:0]    w_rnd_x;

    // on a mantissa carry-out the fraction field is all zeros either way
    always_comb begin
        w_rnd_q = {r_sign, w_e_rnd[NEXP-1:0], w_sum[NSIG-1:0]};
        w_rnd_f = F_NORM;
        w_rnd_x = {4'b0000, w_inexact};
        if (w_ovf) begin
            w_rnd_q = {r_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
            w_rnd_f = F_INF;
            w_rnd_x = X_OVF | 5'b00001;
        end else if (w_tiny) begin
            w_rnd_x = {3'b000, w_inexact, w_inexact};
            if (w_sum[NSIG]) begin
                w_rnd_q = {r_sign, {{(NEXP-1){1'b0}}, 1'b1}, w_sum[NSIG-1:0]};
            end else if (w_sum[NSIG-1:0] == '0) begin
                w_rnd_q = {r_sign, {(W-1){1'b0}}};
                w_rnd_f = F_ZERO;
            end else begin
                w_rnd_q = {r_sign, {NEXP{1'b0}}, w_sum[NSIG-1:0]};
                w_rnd_f = F_SUB;
            end
        end
    end

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_UNPACK;
            S_UNPACK: w_state_next = w_spec ? S_DONE : S_DIVIDE;
            S_DIVIDE: if (r_cnt == CNT_LAST) w_state_next = S_ROUND;
            S_ROUND:  w_state_next = S_DONE;
            S_DONE:   w_state_next = start ? S_UNPACK : S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_flags <= '0;
            r_exc   <= '0;
            r_sign  <= 1'b0;
            r_e     <= '0;
            r_div   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a <= a;
                        r_b <= b;
                    end
                end
                S_UNPACK: begin
                    r_sign <= w_sign;
                    r_e    <= w_e_un;
                    r_div  <= w_man[1];
                    r_rem  <= w_lt ? {w_man[0], 1'b0} : {1'b0, w_man[0]};
                    r_quo  <= '0;
                    r_cnt  <= '0;
                    if (w_spec) begin
                        r_q     <= w_spec_q;
                        r_flags <= w_spec_f;
                        r_exc   <= w_spec_x;
                    end
                end
                S_DIVIDE: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[QW-2:0], w_qbit};
                    r_cnt <= r_cnt + CW'(1);
                end
                S_ROUND: begin
                    r_q     <= w_rnd_q;
                    r_flags <= w_rnd_f;
                    r_exc   <= w_rnd_x;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state == S_UNPACK) || (r_state == S_DIVIDE) || (r_state == S_ROUND);
    assign done      = (r_state == S_DONE);
    assign q         = r_q;
    assign bfFlags   = r_flags;
    assign exception = r_exc;

endmodule

// File: tb/tb_bf_div_iter.sv
// Bench for bf_div_iter: directed vectors, randomized operands against an
// exact integer-ratio reference, handshake and reset-abort scenarios.
module tb_bf_div_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done;
    logic [15:0] q;
    logic [5:0]  bfFlags;
    logic [4:0]  exception;

    int total = 0;
    int bad   = 0;

    bf_div_iter #(.NEXP(8), .NSIG(7)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .q(q), .bfFlags(bfFlags), .exception(exception)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a, b, q;
        logic [5:0]  f;
        logic [4:0]  x;
        int          lat;
    } vec_t;

    // exact reference: quotient as a wide integer ratio, rounded RNE into bf16
    function automatic void ref_div(input logic [15:0] xa, input logic [15:0] xb,
                                    output logic [15:0] rq, output logic [5:0] rf,
                                    output logic [4:0] rx, output bit rspec);
        logic s;
        int ea, eb, fa, fb, base, p, vexp, sh, biased;
        bit nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b, tiny, inexact, up;
        longint unsigned ma, mb, qi, rm, kept, rb, half;
        s  = xa[15] ^ xb[15];
        ea = int'(xa[14:7]); fa = int'(xa[6:0]);
        eb = int'(xb[14:7]); fb = int'(xb[6:0]);
        nan_a  = (ea == 255) && (fa != 0);  nan_b  = (eb == 255) && (fb != 0);
        snan_a = nan_a && !xa[6];           snan_b = nan_b && !xb[6];
        inf_a  = (ea == 255) && (fa == 0);  inf_b  = (eb == 255) && (fb == 0);
        zero_a = (ea == 0) && (fa == 0);    zero_b = (eb == 0) && (fb == 0);
        rspec = 1'b1; rq = 16'h7FC0; rf = 6'b010000; rx = 5'b00000;
        if (nan_a || nan_b) begin
            rx = (snan_a || snan_b) ? 5'b10000 : 5'b00000;
        end else if ((zero_a && zero_b) || (inf_a && inf_b)) begin
            rx = 5'b10000;
        end else if (zero_b) begin
            rq = {s, 15'h7F80}; rf = 6'b001000; rx = 5'b01000;
        end else if (inf_a) begin
            rq = {s, 15'h7F80}; rf = 6'b001000;
        end else if (inf_b || zero_a) begin
            rq = {s, 15'h0000}; rf = 6'b000100;
        end else begin
            rspec = 1'b0;
            ma = longint'(fa + ((ea != 0) ? 128 : 0));
            mb = longint'(fb + ((eb != 0) ? 128 : 0));
            base = ((ea == 0) ? 1 : ea) - ((eb == 0) ? 1 : eb) - 40;
            qi = (ma << 40) / mb;
            rm = (ma << 40) % mb;
            p = 0;
            for (int k = 0; k < 64; k++) if (qi[k]) p = k;
            vexp = p + base;
            tiny = (vexp < -126);
            sh = (tiny ? -133 : (vexp - 7)) - base;
            if (sh >= 60) begin
                kept = 0; up = 1'b0; inexact = 1'b1;
            end else begin
                rb   = qi & ((64'd1 << sh) - 64'd1);
                half = 64'd1 << (sh - 1);
                kept = qi >> sh;
                up = (rb > half) || ((rb == half) && ((rm != 0) || kept[0]));
                inexact = (rb != 0) || (rm != 0);
            end
            kept = kept + (up ? 64'd1 : 64'd0);
            if (!tiny) begin
                biased = vexp + 127;
                if (kept == 256) begin kept = 128; biased++; end
                if (biased >= 255) begin
                    rq = {s, 15'h7F80}; rf = 6'b001000; rx = 5'b00101;
                end else begin
                    rq = {s, biased[7:0], kept[6:0]}; rf = 6'b000001; rx = {4'b0000, inexact};
                end
            end else begin
                rx = {3'b000, inexact, inexact};
                if (kept == 128) begin
                    rq = {s, 8'd1, 7'd0}; rf = 6'b000001;
                end else if (kept == 0) begin
                    rq = {s, 15'h0000}; rf = 6'b000100;
                end else begin
                    rq = {s, 8'd0, kept[6:0]}; rf = 6'b000010;
                end
            end
        end
    endfunction

    function automatic logic [15:0] rand_op();
        int unsigned sel;
        logic [15:0] v;
        sel = $urandom_range(0, 9);
        v = 16'($urandom);
        case (sel)
            4, 5: v[14:7] = 8'($urandom_range(0, 3));
            6, 7: v[14:7] = 8'($urandom_range(250, 254));
            8: case ($urandom_range(0, 3))
                   0: v[14:0] = 15'h0000;
                   1: v[14:0] = 15'h7F80;
                   2: v[14:0] = {8'hFF, 1'b1, 6'($urandom)};
                   default: v[14:0] = {8'hFF, 1'b0, 6'($urandom_range(1, 63))};
               endcase
            9: v[14:7] = 8'($urandom_range(120, 135));
            default: ;
        endcase
        return v;
    endfunction

    // called just after a rising edge; returns in the done cycle (lat=-1 on timeout)
    task automatic run_op(input logic [15:0] xa, input logic [15:0] xb,
                          output logic [15:0] oq, output logic [5:0] of,
                          output logic [4:0] ox, output int lat, output int nbusy);
        a = xa; b = xb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat = 1; nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
        oq = q; of = bfFlags; ox = exception;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (q !== 16'h0000)      begin bad++; $display("FAIL reset_q: got %h want 0000", q); end
        total++; if (bfFlags !== 6'b0)    begin bad++; $display("FAIL reset_flags: got %b want 0", bfFlags); end
        total++; if (exception !== 5'b0)  begin bad++; $display("FAIL reset_exc: got %b want 0", exception); end
        rst = 1'b0;
        $display("reset: busy=%b done=%b q=%h", busy, done, q);
    endtask

    task automatic test_directed();
        vec_t vecs[$];
        logic [15:0] oq; logic [5:0] of; logic [4:0] ox; int lat, nb;
        vecs.push_back('{16'h40C0, 16'h4040, 16'h4000, 6'b000001, 5'b00000, 13});
        vecs.push_back('{16'h3F80, 16'h4040, 16'h3EAB, 6'b000001, 5'b00001, 13});
        vecs.push_back('{16'h3F80, 16'h0000, 16'h7F80, 6'b001000, 5'b01000, 2});
        vecs.push_back('{16'h0000, 16'h0000, 16'h7FC0, 6'b010000, 5'b10000, 2});
        vecs.push_back('{16'h7F81, 16'h3F80, 16'h7FC0, 6'b010000, 5'b10000, 2});
        vecs.push_back('{16'h7F7F, 16'h3E80, 16'h7F80, 6'b001000, 5'b00101, 13});
        vecs.push_back('{16'hFF7F, 16'h3E80, 16'hFF80, 6'b001000, 5'b00101, 13});
        vecs.push_back('{16'h0080, 16'h4000, 16'h0040, 6'b000010, 5'b00000, 13});
        vecs.push_back('{16'h0080, 16'h4040, 16'h002B, 6'b000010, 5'b00011, 13});
        vecs.push_back('{16'h7FC0, 16'h0000, 16'h7FC0, 6'b010000, 5'b00000, 2});
        vecs.push_back('{16'hFF80, 16'h4000, 16'hFF80, 6'b001000, 5'b00000, 2});
        vecs.push_back('{16'h0000, 16'h3F80, 16'h0000, 6'b000100, 5'b00000, 2});
        vecs.push_back('{16'h3F80, 16'h7F80, 16'h0000, 6'b000100, 5'b00000, 2});
        vecs.push_back('{16'h8000, 16'h3F80, 16'h8000, 6'b000100, 5'b00000, 2});
        vecs.push_back('{16'h0001, 16'h7F00, 16'h0000, 6'b000100, 5'b00011, 13});
        vecs.push_back('{16'h00FF, 16'h4000, 16'h0080, 6'b000001, 5'b00011, 13});
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, oq, of, ox, lat, nb);
            $display("dir %0d: a=%h b=%h q=%h flags=%b exc=%b lat=%0d", i, vecs[i].a, vecs[i].b, oq, of, ox, lat);
            total++; if (lat != vecs[i].lat) begin bad++; $display("FAIL dir%0d_lat: got %0d want %0d", i, lat, vecs[i].lat); end
            total++; if (oq !== vecs[i].q)   begin bad++; $display("FAIL dir%0d_q: got %h want %h", i, oq, vecs[i].q); end
            total++; if (of !== vecs[i].f)   begin bad++; $display("FAIL dir%0d_flags: got %b want %b", i, of, vecs[i].f); end
            total++; if (ox !== vecs[i].x)   begin bad++; $display("FAIL dir%0d_exc: got %b want %b", i, ox, vecs[i].x); end
            total++; if (nb != vecs[i].lat - 1) begin bad++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, nb, vecs[i].lat - 1); end
            total++; if (busy !== 1'b0)      begin bad++; $display("FAIL dir%0d_busy_at_done: got %b want 0", i, busy); end
            @(posedge clk); #1;
            total++; if (done !== 1'b0)      begin bad++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, done); end
        end
    endtask

    task automatic test_random();
        logic [15:0] xa, xb, oq, eq; logic [5:0] of, ef; logic [4:0] ox, ex; int lat, nb; bit sp;
        for (int n = 0; n < 400; n++) begin
            xa = rand_op(); xb = rand_op();
            ref_div(xa, xb, eq, ef, ex, sp);
            run_op(xa, xb, oq, of, ox, lat, nb);
            $display("rnd %0d: a=%h b=%h q=%h/%h flags=%b/%b exc=%b/%b", n, xa, xb, oq, eq, of, ef, ox, ex);
            total++; if (lat != (sp ? 2 : 13)) begin bad++; $display("FAIL rnd_lat: got %0d want %0d", lat, sp ? 2 : 13); end
            total++; if (oq !== eq) begin bad++; $display("FAIL rnd_q: a=%h b=%h got %h want %h", xa, xb, oq, eq); end
            total++; if (of !== ef) begin bad++; $display("FAIL rnd_flags: a=%h b=%h got %b want %b", xa, xb, of, ef); end
            total++; if (ox !== ex) begin bad++; $display("FAIL rnd_exc: a=%h b=%h got %b want %b", xa, xb, ox, ex); end
            total++; if ($onehot(of) !== 1'b1) begin bad++; $display("FAIL rnd_onehot: got %b want one-hot", of); end
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        a = 16'h40C0; b = 16'h4040; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        while (!done && cyc < 40) begin
            if (cyc == 5) begin a = 16'h3F80; b = 16'h4040; start = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        $display("ignore_start: q=%h done_cycle=%0d", q, cyc);
        total++; if (!done || cyc != 13) begin bad++; $display("FAIL ignore_lat: got %0d want 13", cyc); end
        total++; if (q !== 16'h4000)     begin bad++; $display("FAIL ignore_q: got %h want 4000", q); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        a = 16'h40C0; b = 16'h4040; start = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        while (!done && cyc < 40) begin @(posedge clk); #1; cyc++; end
        total++; if (!done || cyc != 13) begin bad++; $display("FAIL b2b_first_lat: got %0d want 13", cyc); end
        total++; if (q !== 16'h4000)     begin bad++; $display("FAIL b2b_first_q: got %h want 4000", q); end
        a = 16'h3F80;
        @(posedge clk); #1;
        start = 1'b0; cyc++;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_pulse: got %b want 0", done); end
        while (!done && cyc < 60) begin @(posedge clk); #1; cyc++; end
        $display("back_to_back: second q=%h done_cycle=%0d", q, cyc);
        total++; if (!done || cyc != 26) begin bad++; $display("FAIL b2b_second_lat: got %0d want 26", cyc); end
        total++; if (q !== 16'h3EAB)     begin bad++; $display("FAIL b2b_second_q: got %h want 3eab", q); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int cyc, ndone, lat, nb;
        logic [15:0] oq; logic [5:0] of; logic [4:0] ox;
        a = 16'h40C0; b = 16'h4040; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        while (cyc < 6) begin @(posedge clk); #1; cyc++; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (q !== 16'h0000)     begin bad++; $display("FAIL abort_q: got %h want 0000", q); end
        total++; if (bfFlags !== 6'b0)   begin bad++; $display("FAIL abort_flags: got %b want 0", bfFlags); end
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        total++; if (ndone != 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone); end
        run_op(16'h3F80, 16'h4040, oq, of, ox, lat, nb);
        $display("reset_abort: post-reset q=%h lat=%0d", oq, lat);
        total++; if (lat != 13)      begin bad++; $display("FAIL abort_next_lat: got %0d want 13", lat); end
        total++; if (oq !== 16'h3EAB) begin bad++; $display("FAIL abort_next_q: got %h want 3eab", oq); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bf_div_iter.md
Name: bf_div_iter

Overview:
- Iterative bfloat16 divider, q = a / b; the companion of the combinational hp_mul in the float-processing datapath.
- Restoring significand division retires one quotient bit per cycle, then one normalise/round cycle.
- Same flag/exception vocabulary as the multiplier.
- Start/done handshake. One operation in flight at a time.

Parameters:
- NEXP, 8, exponent width (bias = 2^(NEXP-1)-1)
- NSIG, 7, stored fraction width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- a  in  NEXP+NSIG+1  dividend, sampled with start
- b  in  NEXP+NSIG+1  divisor, sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; q/bfFlags/exception valid from this cycle
- q  out  NEXP+NSIG+1  quotient
- bfFlags  out  6  result class, one-hot: [5]SNAN [4]QNAN [3]INFINITY [2]ZERO [1]SUBNORMAL [0]NORMAL
- exception  out  5  [4]INVALID [3]DIVBYZERO [2]OVERFLOW [1]UNDERFLOW [0]INEXACT

Behaviour:
- Reset: state=IDLE; busy=0, done=0, q=0, bfFlags=0, exception=0.
- rst in any state aborts the operation; no done is produced.
- States and transitions:
  - IDLE -> UNPACK on start.
  - UNPACK -> DONE for special cases.
  - UNPACK -> DIVIDE otherwise.
  - DIVIDE runs NSIG+3 cycles -> ROUND.
  - ROUND -> DONE.
  - DONE -> IDLE, or -> UNPACK if start is asserted in DONE.
- busy=0 in IDLE and DONE; start is accepted in both.
- start while busy=1 is ignored; operands are not resampled.
- Latency, counted from the edge that samples start:
  - normal path: done high at cycle NSIG+6 (13 at default);
  - special path: done high at cycle 2.
- Outputs hold their last value until the next done.
- UNPACK:
  - classify a and b.
  - subnormal operands: normalise the significand to 1.xxx and record the shift.
  - sign = sa ^ sb.
  - biased exponent e = ea - eb + bias - shift_a + shift_b, held as signed NEXP+3 bits.
  - if ma < mb: dividend <<= 1 and e -= 1. The quotient is then always in [1,2).
- Special cases (resolved in UNPACK):
  - either operand NaN -> q = 0x7FC0 (sign 0), QNAN; INVALID only if either input is an sNaN.
  - 0/0 or inf/inf -> 0x7FC0, QNAN, INVALID.
  - finite nonzero / 0 -> signed inf, INFINITY, DIVBYZERO.
  - inf / finite -> signed inf, INFINITY, no exception.
  - finite / inf or 0 / nonzero finite -> signed zero, ZERO.
- DIVIDE (restoring):
  - each cycle: trial = rem - divisor; if trial >= 0, quotient bit = 1 and rem = trial; rem <<= 1.
  - produces 1 integer bit, NSIG fraction bits, then guard and round bits.
  - sticky = (final rem != 0).
- ROUND:
  - round to nearest, ties to even.
  - mantissa carry-out increments e.
  - e >= 2^NEXP-1 after rounding -> signed inf, INFINITY, OVERFLOW|INEXACT.
  - e <= 0 -> shift right by (1-e), ORing shifted-out bits into sticky, then round. Shift is capped at NSIG+3, so everything beyond becomes sticky.
  - subnormal result: exponent field 0, SUBNORMAL. If rounding carries into the hidden bit, exponent field 1 and NORMAL.
  - result that rounds to 0 -> signed zero, ZERO.
- Exception rules:
  - INEXACT = guard|round|sticky after the final alignment.
  - UNDERFLOW = result tiny (e <= 0 before rounding) AND inexact.
- bfFlags is exactly one-hot whenever done=1.

Test Plan:
- a=0x40C0 (6.0), b=0x4040 (3.0), start 1 cycle -> done at cycle 13; q=0x4000, bfFlags[0]=1, exception=0; busy high cycles 1-12.
- a=0x3F80 (1.0), b=0x4040 (3.0) -> q=0x3EAB (rounded up, G=1, S=1), NORMAL, exception=00001.
- a=0x3F80, b=0x0000 -> done at cycle 2; q=0x7F80, INFINITY, exception=01000. Then a=0x0000, b=0x0000 -> q=0x7FC0, QNAN, exception=10000. Then a=0x7F81 (sNaN), b=0x3F80 -> q=0x7FC0, INVALID.
- a=0x7F7F, b=0x3E80 (0.25) -> q=0x7F80, INFINITY, exception=00101. Then a=0xFF7F, b=0x3E80 -> q=0xFF80.
- a=0x0080, b=0x4000 -> q=0x0040, SUBNORMAL, exception=0 (exact, no underflow). Then a=0x0080, b=0x4040 -> q=0x002B, SUBNORMAL, exception=00011.
- Handshake/reset:
  - start pulsed again at cycle 5 -> ignored; q=0x4000 at cycle 13 as before.
  - start held through DONE -> next op accepted, back-to-back done pulses 13 cycles apart.
  - rst at cycle 6 -> busy=0, q=0, no done; a new start afterwards completes normally.
